// File: rtl/aes_pkg.sv
// Shared definitions for the AES key schedule: key length codes, Nk/Nr, FSM states, Rcon seed.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    // key_len encodings presented with start
    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_RSV = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GEN  = 2'b01,
        ST_OUT  = 2'b10
    } ks_state_e;

    // Key length in 32-bit words
    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    // Number of rounds (round keys are indexed 0..Nr)
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) with the AES reduction polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a - input byte; y - substituted byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Row r holds entries 16r..16r+15; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128/192/256 key expansion producing one 128-bit round key per valid/ready handshake.
// Latency: 4 cycles of word generation per round key, then held until accepted (5 cycles/key at full rate).
// Backpressure: rk_ready low in OUT freezes rk_data/rk_index/rk_last; generation resumes only after the handshake.
// Ports: clk, rst (async, active high); start/key_len/key_in sampled in IDLE; busy;
//        rk_valid/rk_ready/rk_data/rk_index/rk_last round-key stream; done pulses after the final key.
// Build option: define AES_KS_192_EN to accept key_len=01 (AES-192); otherwise it is rejected like 11.
module aes_key_scheduler
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         done
);

    ks_state_e    state_q, state_d;

    logic [31:0]  key_w [8];    // latched cipher key, word 0 first
    logic [31:0]  win   [8];    // win[0] = w[wc-1], win[k] = w[wc-1-k]
    logic [127:0] rk_buf;
    logic [5:0]   wc;           // word counter, up to 4*(Nr+1)
    logic [2:0]   pos;          // wc mod Nk, tracked incrementally
    logic [3:0]   nk, nr;
    logic [3:0]   rk_idx;
    logic [7:0]   rcon;
    logic         done_q;

    logic         kl_legal;
    logic [3:0]   nk_sel, nr_sel;
    logic         start_ok, hs, gen;

    logic [31:0]  prev, old, rot_word, sub_in, sub_out, temp, w_new;
    logic [2:0]   old_idx;
    logic         use_key, at_rcon;

    // ---------------- key length decode ----------------
    always_comb begin
        kl_legal = 1'b0;
        nk_sel   = NK_128;
        nr_sel   = NR_128;
        case (key_len)
            KL_128: begin
                kl_legal = 1'b1;
                nk_sel   = NK_128;
                nr_sel   = NR_128;
            end
`ifdef AES_KS_192_EN
            KL_192: begin
                kl_legal = 1'b1;
                nk_sel   = NK_192;
                nr_sel   = NR_192;
            end
`endif
            KL_256: begin
                kl_legal = 1'b1;
                nk_sel   = NK_256;
                nr_sel   = NR_256;
            end
            default: kl_legal = 1'b0;
        endcase
    end

    assign start_ok = (state_q == ST_IDLE) && start && kl_legal;
    assign gen      = (state_q == ST_GEN);
    assign hs       = (state_q == ST_OUT) && rk_ready;

    // ---------------- outputs ----------------
    assign busy     = (state_q != ST_IDLE);
    assign rk_valid = (state_q == ST_OUT);
    assign rk_last  = rk_valid && (rk_idx == nr);
    assign rk_data  = rk_buf;
    assign rk_index = rk_idx;
    assign done     = done_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_GEN;
            // wc[1:0]==3 marks the fourth word of the current round key
            ST_GEN:  if (wc[1:0] == 2'b11) state_d = ST_OUT;
            ST_OUT:  if (rk_ready) state_d = rk_last ? ST_IDLE : ST_GEN;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- word expansion ----------------
    // nk-1 in three bits: 4->3, 6->5, 8->7 (8 wraps to 0 before the subtract)
    assign old_idx  = nk[2:0] - 3'd1;
    assign prev     = win[0];
    assign old      = win[old_idx];
    assign rot_word = {prev[23:0], prev[31:24]};
    assign at_rcon  = (pos == 3'd0);
    assign use_key  = (wc < {2'b00, nk});
    assign sub_in   = at_rcon ? rot_word : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .y (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (at_rcon) begin
            temp = sub_out ^ {rcon, 24'h000000};
        end else if ((nk == NK_256) && (pos == 3'd4)) begin
            // AES-256 only: extra SubWord half way through each 8-word group
            temp = sub_out;
        end
    end

    assign w_new = use_key ? key_w[wc[2:0]] : (old ^ temp);

    // ---------------- datapath state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                key_w[i] <= '0;
                win[i]   <= '0;
            end
            rk_buf <= '0;
            wc     <= '0;
            pos    <= '0;
            nk     <= NK_128;
            nr     <= NR_128;
            rk_idx <= '0;
            rcon   <= RCON_INIT;
            done_q <= 1'b0;
        end else begin
            done_q <= hs && rk_last;

            if (start_ok) begin
                for (int i = 0; i < 8; i++) begin
                    key_w[i] <= key_in[255 - 32*i -: 32];
                end
                nk     <= nk_sel;
                nr     <= nr_sel;
                wc     <= '0;
                pos    <= '0;
                rk_idx <= '0;
                rcon   <= RCON_INIT;
            end

            if (gen) begin
                for (int i = 7; i > 0; i--) begin
                    win[i] <= win[i-1];
                end
                win[0] <= w_new;
                rk_buf <= {rk_buf[95:0], w_new};
                wc     <= wc + 6'd1;
                pos    <= ({1'b0, pos} == (nk - 4'd1)) ? 3'd0 : pos + 3'd1;
                if (!use_key && at_rcon) begin
                    rcon <= xtime(rcon);
                end
            end

            if (hs && !rk_last) begin
                rk_idx <= rk_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Scoreboard bench for aes_key_scheduler using FIPS-197 key expansion vectors.
// Latency: checks 55-cycle AES-128 schedule at full rate and 132 cycles with 7-cycle stalls.
// Backpressure: rk_ready held high, or dropped for 7 cycles in every OUT window.
module tb_aes_key_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         done;

    always #5 clk = ~clk;

    aes_key_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .rk_last  (rk_last),
        .done     (done)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         last;
        logic         chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic stall_mode = 1'b0;
    int   stall_cnt  = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hffffffff_ffffffff};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [127:0] data, input logic last, input logic chk);
        exp_t e;
        e.idx  = 4'(idx);
        e.data = data;
        e.last = last;
        e.chk  = chk;
        sb_q.push_back(e);
    endtask

    task automatic push_aes128();
        push(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1);
        push(1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b1);
        push(2, 128'hf2c295f27a96b9435935807a7359f67f, 1'b0, 1'b1);
        for (int j = 3; j < 10; j++) push(j, '0, 1'b0, 1'b0);
        push(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b1);
    endtask

    // ---------------- rk_ready driver ----------------
    always @(posedge clk) begin
        #1;
        if (!stall_mode) begin
            rk_ready = 1'b1;
        end else if (!rk_valid) begin
            rk_ready  = 1'b1;   // toggled outside OUT; must have no effect
            stall_cnt = 0;
        end else if (stall_cnt < 7) begin
            rk_ready = 1'b0;
            stall_cnt++;
        end else begin
            rk_ready  = 1'b1;
            stall_cnt = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [127:0] hold_data;
    logic [3:0]   hold_idx;
    logic         hold_last;
    logic         hold_vld = 1'b0;
    logic         done_due = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_vld = 1'b0;
            done_due = 1'b0;
        end else begin
            if (done_due) begin
                check("done_pulse", done, 1'b1);
                done_due = 1'b0;
            end else if (done) begin
                check("done_spurious", done, 1'b0);
            end
            if (rk_valid && !busy) check("valid_needs_busy", busy, 1'b1);
            if (rk_valid && hold_vld) begin
                check("stall_data", rk_data, hold_data);
                check("stall_index", rk_index, hold_idx);
                check("stall_last", rk_last, hold_last);
            end
            if (rk_valid && rk_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rk", rk_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("rk_index", rk_index, e.idx);
                    check("rk_last", rk_last, e.last);
                    if (e.chk) check("rk_data", rk_data, e.data);
                    if (rk_last) done_due = 1'b1;
                end
                hold_vld = 1'b0;
            end else if (rk_valid) begin
                hold_vld  = 1'b1;
                hold_data = rk_data;
                hold_idx  = rk_index;
                hold_last = rk_last;
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        @(posedge clk); #1;
        start   = 1'b1;
        key_len = kl;
        key_in  = k;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = ~k;    // key must have been latched with start
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check({name, "_timeout"}, done, 1'b1);
    endtask

    task automatic quiet_window(input string name, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (busy || rk_valid || done) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int cyc;
        rst     = 1'b1;
        start   = 1'b0;
        key_len = 2'b00;
        key_in  = '0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_last", rk_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", rk_data, '0);
        check("rst_index", rk_index, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // AES-128 at full rate
        push_aes128();
        do_start(2'b00, K128);
        check("busy_after_start", busy, 1'b1);
        wait_done("aes128", cyc);
        check("aes128_latency", cyc, 55);
        check("aes128_drained", sb_q.size(), 0);
        check("aes128_idle", busy, 1'b0);

        // AES-256
        push(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1);
        push(1, 128'h101112131415161718191a1b1c1d1e1f, 1'b0, 1'b1);
        push(2, 128'ha573c29fa176c498a97fce93a572c09c, 1'b0, 1'b1);
        for (int j = 3; j < 14; j++) push(j, '0, 1'b0, 1'b0);
        push(14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b1, 1'b1);
        do_start(2'b10, K256);
        wait_done("aes256", cyc);
        check("aes256_latency", cyc, 75);
        check("aes256_drained", sb_q.size(), 0);

`ifdef AES_KS_192_EN
        push(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1);
        push(1, 128'h10111213141516175846f2f95c43f4fe, 1'b0, 1'b1);
        for (int j = 2; j < 12; j++) push(j, '0, 1'b0, 1'b0);
        push(12, 128'ha4970a331a78dc09c418c271e3a41d5d, 1'b1, 1'b1);
        do_start(2'b01, K192);
        wait_done("aes192", cyc);
        check("aes192_latency", cyc, 65);
        check("aes192_drained", sb_q.size(), 0);
`else
        do_start(2'b01, K192);
        quiet_window("aes192_rejected", 20);
`endif

        // Reserved key length
        do_start(2'b11, K256);
        quiet_window("reserved_rejected", 20);

        // AES-128 with 7-cycle stalls on every key and a stray start while busy
        stall_mode = 1'b1;
        push_aes128();
        do_start(2'b00, K128);
        repeat (10) @(posedge clk);
        #1;
        start   = 1'b1;
        key_len = 2'b10;
        key_in  = K256;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("stall", cyc);
        check("stall_latency", cyc + 11, 132);
        check("stall_drained", sb_q.size(), 0);
        stall_mode = 1'b0;

        // Reset during GEN of round key 3
        push(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1);
        push(1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b1);
        push(2, 128'hf2c295f27a96b9435935807a7359f67f, 1'b0, 1'b1);
        do_start(2'b00, K128);
        repeat (16) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_popped", sb_q.size(), 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", rk_valid, 1'b0);
        check("midrst_last", rk_last, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_data", rk_data, '0);
        check("midrst_index", rk_index, '0);
        sb_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        quiet_window("midrst_abandoned", 40);

        // First start after reset repeats the AES-128 result exactly
        push_aes128();
        do_start(2'b00, K128);
        wait_done("post_rst", cyc);
        check("post_rst_latency", cyc, 55);
        check("post_rst_drained", sb_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
